conv3x3_stream: RTL
===================

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameter IMG_W, default 320, pixels per stored line.
REQ-002 Parameter IMG_H, default 240, stored lines per frame.
REQ-003 pclk  input  1  pixel clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_we  input  1  capture write strobe; one pixel accepted per high cycle.
REQ-006 in_addr  input  17  capture write address; value 0 marks frame start.
REQ-007 in_data  input  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
REQ-008 mode  input  2  kernel select: 0 pass, 1 blur, 2 Sobel, 3 Laplacian.
REQ-009 out_we  output  1  filtered pixel write strobe.
REQ-010 out_addr  output  17  frame-buffer address of filtered centre pixel.
REQ-011 out_data  output  12  filtered grey pixel, RGB444.
REQ-012 frame_done  output  1  one-cycle pulse with last filtered pixel of a frame.

Function
REQ-013 Accepted pixel SHALL convert to grey g = R + 2G + B, 6 bits, range 0..60.
REQ-014 Block SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters.
- Position of each accepted pixel = current (row, col).
- After the pixel, col increments.
- col wraps IMG_W-1 -> 0 and increments row.
- row saturates at IMG_H-1.
REQ-015 in_we with in_addr==0 SHALL force that pixel to (0,0), regardless of counter state.
REQ-016 mode SHALL be latched only on a frame-start pixel (REQ-015); it is held for the whole frame.
REQ-017 Two line buffers of IMG_W x 6 bits plus a 3x3 window register SHALL hold grey rows row-2, row-1, row; they shift only on in_we.
REQ-018 For a pixel at (r,c) with r>=2 and c>=2, block SHALL emit centre (r-1,c-1).
- out_addr = (r-1)*IMG_W + (c-1).
- Border rows/columns are never emitted: 75684 writes per 320x240 frame.
REQ-019 Latency SHALL be exactly 3 cycles, in_we to out_we (pipeline: window, accumulate, abs/saturate).
- Back-to-back in_we on consecutive cycles SHALL be supported with no loss.
REQ-020 Kernel results y, 6 bits:
- Pass: y = centre.
- Blur: y = (1 2 1; 2 4 2; 1 2 1)-weighted sum >> 4, truncated.
- Sobel: y = min(|Gx|+|Gy|, 63).
  - Gx = right column minus left column, weights 1,2,1.
  - Gy = bottom row minus top row, weights 1,2,1.
- Laplacian: y = min(|8*centre - sum of 8 neighbours|, 63).
REQ-021 Intermediate sums SHALL be signed 11 bits; no overflow is permitted before saturation.
REQ-022 out_data SHALL be {y[5:2], y[5:2], y[5:2]}.
REQ-023 frame_done SHALL pulse with out_we for centre (IMG_H-2, IMG_W-2).
REQ-024 Frame start mid-frame SHALL discard window history.
- No output is emitted until the new frame reaches row 2, col 2.
- In-flight pipeline outputs of the old frame still complete.
REQ-025 Cycles without in_we SHALL leave counters, window and pipeline data unchanged.
- out_we SHALL be low on those cycles unless a prior pixel's output falls due.

Reset
REQ-026 reset_n low SHALL immediately clear all of the following:
- out_we, frame_done, out_addr, out_data, row, col, window and pipeline valid bits.
- latched mode, to 0.
REQ-027 Line-buffer contents need not be cleared; they SHALL NOT affect outputs before row 2 of the next frame.
REQ-028 After reset release, the first frame-start pixel SHALL begin normal operation; out_we stays low until then.

Verification
REQ-029 Uniform 0xFFF frame, mode 1.
- 75684 writes, all 0xFFF.
- First out_addr 321, last 76478.
- frame_done coincides with addr 76478.
REQ-030 Same frame, mode 2 -> all outputs 0x000; mode 3 -> all outputs 0x000.
REQ-031 Vertical edge (cols<160 = 0x000, cols>=160 = 0xFFF), mode 2.
- Centres at col 159 and 160 output 0xFFF (Gx=240, saturated).
- All other centres output 0x000.
REQ-032 Single pixel 0x888 (g=32) at (5,5) in a 0x000 frame, mode 0.
- Output at addr 1605 = 0x888.
- Output appears exactly 3 cycles after the in_we of pixel (6,6).
REQ-033 Frame-start pixel injected at row 100 -> no out_we until new (2,2) plus 3 cycles; next output addr 321.
REQ-034 reset_n asserted mid-frame with in_we every cycle.
- out_we low within the same cycle.
- Normal outputs resume only after the next frame start.

Source files
------------

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 grey-scale filter over a captured RGB444 frame.
// The output pipeline is window -> accumulate -> abs/saturate, giving 3 cycles from in_we to out_we.
module conv3x3_stream #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        in_we,
    input  logic [16:0] in_addr,
    input  logic [11:0] in_data,
    input  logic [1:0]  mode,
    output logic        out_we,
    output logic [16:0] out_addr,
    output logic [11:0] out_data,
    output logic        frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {K_PASS = 2'd0, K_BLUR = 2'd1, K_SOBEL = 2'd2, K_LAP = 2'd3} kernel_t;

    logic [CW-1:0]      col, pos_col;
    logic [RW-1:0]      row, pos_row;
    logic               started;
    kernel_t            mode_q, mode1;
    logic               frame_start, accept, emit;
    logic [5:0]         grey, lb1_rd, lb2_rd;
    logic [5:0]         lb1 [IMG_W];
    logic [5:0]         lb2 [IMG_W];
    logic [5:0]         win [3][3];
    logic               v1, last1, v2, last2;
    logic [16:0]        ctr_addr, addr1, addr2;
    logic signed [10:0] top, mid, bot, lft, rgt, ring, acc_a, acc_b, a2, b2;
    logic [10:0]        mag;
    logic [3:0]         y_hi;

    function automatic logic signed [10:0] ext(input logic [5:0] x);
        return signed'({5'b0, x});
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] x);
        return (x < 0) ? 11'(-x) : 11'(x);
    endfunction

    assign frame_start = in_we && (in_addr == '0);
    assign accept      = in_we && (started || frame_start);
    assign pos_col     = frame_start ? '0 : col;
    assign pos_row     = frame_start ? '0 : row;
    assign grey        = 6'(in_data[11:8]) + 6'({in_data[7:4], 1'b0}) + 6'(in_data[3:0]);
    assign lb1_rd      = lb1[pos_col];
    assign lb2_rd      = lb2[pos_col];
    assign emit        = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    assign ctr_addr    = 17'((int'(pos_row) - 1) * IMG_W + int'(pos_col) - 1);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            col     <= '0;
            row     <= '0;
            started <= 1'b0;
            mode_q  <= K_PASS;
        end else begin
            if (frame_start) begin
                started <= 1'b1;
                mode_q  <= kernel_t'(mode);
            end
            if (accept) begin
                if (pos_col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (pos_row == RW'(IMG_H - 1)) ? pos_row : pos_row + RW'(1);
                end else begin
                    col <= pos_col + CW'(1);
                    row <= pos_row;
                end
            end
        end
    end

    // Line buffers carry no reset; the row >= 2 gate keeps stale contents out of the output.
    always_ff @(posedge pclk) begin
        if (accept) begin
            lb2[pos_col] <= lb1_rd;
            lb1[pos_col] <= grey;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            v1    <= 1'b0;
            addr1 <= '0;
            last1 <= 1'b0;
            mode1 <= K_PASS;
        end else begin
            v1 <= emit;
            if (accept) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb2_rd;
                win[1][2] <= lb1_rd;
                win[2][2] <= grey;
            end
            if (emit) begin
                addr1 <= ctr_addr;
                last1 <= (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));
                mode1 <= mode_q;
            end
        end
    end

    // acc_b is only non-zero for Sobel, so the last stage is a uniform |a|+|b| saturate.
    always_comb begin
        top   = ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]);
        mid   = ext(win[1][0]) + (ext(win[1][1]) <<< 1) + ext(win[1][2]);
        bot   = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]);
        lft   = ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]);
        rgt   = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]);
        ring  = ext(win[0][0]) + ext(win[0][1]) + ext(win[0][2]) + ext(win[1][0])
              + ext(win[1][2]) + ext(win[2][0]) + ext(win[2][1]) + ext(win[2][2]);
        acc_a = ext(win[1][1]);
        acc_b = '0;
        case (mode1)
            K_BLUR:  acc_a = (top + (mid <<< 1) + bot) >>> 4;
            K_SOBEL: begin
                acc_a = rgt - lft;
                acc_b = bot - top;
            end
            K_LAP:   acc_a = (ext(win[1][1]) <<< 3) - ring;
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            v2    <= 1'b0;
            a2    <= '0;
            b2    <= '0;
            addr2 <= '0;
            last2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                a2    <= acc_a;
                b2    <= acc_b;
                addr2 <= addr1;
                last2 <= last1;
            end
        end
    end

    assign mag  = abs11(a2) + abs11(b2);
    assign y_hi = (mag > 11'd63) ? 4'hF : mag[5:2];

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            out_we     <= 1'b0;
            frame_done <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
        end else begin
            out_we     <= v2;
            frame_done <= v2 && last2;
            if (v2) begin
                out_addr <= addr2;
                out_data <= {y_hi, y_hi, y_hi};
            end
        end
    end
endmodule
